unidade_controle_multiciclo: RTL and testbench



---
 rtl/controle_pkg.sv | 68 ++++++
 rtl/controle_saidas.sv | 96 +++++++++
 rtl/unidade_controle_multiciclo.sv | 109 ++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared constants for the multicycle MIPS control unit: state codes, opcodes and mux encodings.
// State ST_JR exists only when CONTROL_JR_EN is defined.
package controle_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_RD    = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WR    = 4'd5;
  localparam logic [3:0] ST_EXEC_R    = 4'd6;
  localparam logic [3:0] ST_R_WB      = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_JUMP      = 4'd9;
  localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
  localparam logic [3:0] ST_ORI_EXEC  = 4'd11;
  localparam logic [3:0] ST_IMM_WB    = 4'd12;
`ifdef CONTROL_JR_EN
  localparam logic [3:0] ST_JR        = 4'd13;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [1:0] ULAOP_ADD   = 2'b11;
  localparam logic [1:0] ULAOP_SUB   = 2'b01;
  localparam logic [1:0] ULAOP_FUNCT = 2'b00;
  localparam logic [1:0] ULAOP_OR    = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG_A  = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] ula_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/controle_saidas.sv
// Combinational state-to-control decoder; only FETCH and MEM_WR strobes depend on mem_ready.
// JR decode present only with CONTROL_JR_EN.
module controle_saidas
  import controle_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       decode_illegal,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ula_src_b = SRCB_FOUR;
        ctrl.ula_op    = ULAOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Branch target precomputed here into ALUOut
        ctrl.ula_src_b  = SRCB_IMM_SH2;
        ctrl.ula_op     = ULAOP_ADD;
        ctrl.instr_done = decode_illegal;
      end
      ST_MEM_ADDR: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRCB_IMM;
        ctrl.ula_op    = ULAOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_EXEC_R: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRCB_B;
        ctrl.ula_op    = ULAOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.ula_src_a     = 1'b1;
        ctrl.ula_src_b     = SRCB_B;
        ctrl.ula_op        = ULAOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDI_EXEC: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRCB_IMM;
        ctrl.ula_op    = ULAOP_ADD;
      end
      ST_ORI_EXEC: begin
        ctrl.ula_src_a = 1'b1;
        ctrl.ula_src_b = SRCB_IMM;
        ctrl.ula_op    = ULAOP_OR;
      end
      ST_IMM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef CONTROL_JR_EN
      ST_JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_REG_A;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Main control FSM for the multicycle MIPS datapath with mem_ready wait states.
// Define CONTROL_JR_EN to give jr (R-type, funct 0x08) its own 3-cycle JR state.
module unidade_controle_multiciclo
  import controle_pkg::*;
#(
  parameter int unsigned OPC_W = 6,
  parameter int unsigned ST_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OPC_W-1:0] funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             ula_src_a,
  output logic [1:0]       ula_src_b,
  output logic [1:0]       ula_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state_dbg
);

  logic [3:0] state_q, state_d;
  logic       illegal_q;
  logic       decode_illegal;
  ctrl_t      ctrl;

  assign decode_illegal = (state_q == ST_DECODE) && !opcode_known(opcode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
`ifdef CONTROL_JR_EN
          OP_RTYPE:     state_d = (funct == FUNCT_JR) ? ST_JR : ST_EXEC_R;
`else
          OP_RTYPE:     state_d = ST_EXEC_R;
`endif
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          OP_ORI:       state_d = ST_ORI_EXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:    if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR:    if (mem_ready) state_d = ST_FETCH;
      ST_EXEC_R:    state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_IMM_WB;
      ST_ORI_EXEC:  state_d = ST_IMM_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

`ifndef CONTROL_JR_EN
  logic funct_unused;
  assign funct_unused = ^funct;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (decode_illegal) illegal_q <= 1'b1;
    end
  end

  controle_saidas u_saidas (
    .state          (state_q),
    .mem_ready      (mem_ready),
    .decode_illegal (decode_illegal),
    .ctrl           (ctrl)
  );

  // Architectural writes are suppressed while reset is high so an abandoned instruction
  // cannot commit anything on the reset edge.
  assign pc_write      = ctrl.pc_write & ~reset;
  assign pc_write_cond = ctrl.pc_write_cond & ~reset;
  assign mem_write     = ctrl.mem_write & ~reset;
  assign ir_write      = ctrl.ir_write & ~reset;
  assign reg_write     = ctrl.reg_write & ~reset;
  assign instr_done    = ctrl.instr_done & ~reset;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign ula_src_a     = ctrl.ula_src_a;
  assign ula_src_b     = ctrl.ula_src_b;
  assign ula_op        = ctrl.ula_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = illegal_q;
  assign state_dbg     = ST_W'(state_q);

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: per-instruction expected cycle sequences checked every
// cycle, plus literal latency and flag checks. Honours CONTROL_JR_EN like the design.
module tb_unidade_controle_multiciclo;
  import controle_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, ula_src_a, instr_done, illegal_op;
  logic [1:0] ula_src_b, ula_op, pc_source;
  logic [3:0] state_dbg;

  always #5 clock = ~clock;

  unidade_controle_multiciclo #(.OPC_W(6), .ST_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .ula_op(ula_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, uop, pcsrc;
    logic done, ill;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];
  int    checks = 0;
  int    failures = 0;
  logic  model_ill = 1'b0;
  int    lat_cnt = 0, last_lat = 0, done_cnt = 0, wr_cnt = 0;

  // Per-cycle comparison against the model's queued expectations
  always @(negedge clock) begin
    exp_t  e, a;
    string t;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      t = tagq.pop_front();
      a = {state_dbg, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, ula_src_a, ula_src_b, ula_op, pc_source,
           instr_done, illegal_op};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h (t=%0t)", t, a, e, $time);
      end
    end
    if (!reset) begin
      checks++;
      if (mem_write && reg_write) begin
        failures++;
        $display("FAIL excl_wr: got mem_write=1 reg_write=1 want not both (t=%0t)", $time);
      end
      lat_cnt++;
      if (mem_write) wr_cnt++;
      if (instr_done) begin
        last_lat = lat_cnt;
        lat_cnt = 0;
        done_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e = '0;
    e.st  = st;
    e.ill = model_ill;
    return e;
  endfunction

  function automatic exp_t fetch_e();
    exp_t e = blank(ST_FETCH);
    e.mrd = 1'b1; e.srcb = 2'b01; e.uop = 2'b11;
    return e;
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D};
  endfunction

  task automatic step(input exp_t e, input logic rdy, input string tag);
    mem_ready = rdy;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock);
    #1;
    model_ill = 1'b0;
    repeat (n - 1) step(fetch_e(), 1'b0, "reset_hold");
    reset = 1'b0;
  endtask

  // Whole instruction: fetch (with wait states), decode, then the class-specific path
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                     input int mwait, input logic idle_rdy);
    exp_t e;
    opcode = op;
    funct  = fn;
    repeat (fwait) step(fetch_e(), 1'b0, "fetch_wait");
    e = fetch_e(); e.pcw = 1'b1; e.irw = 1'b1;
    step(e, 1'b1, "fetch");
    e = blank(ST_DECODE); e.srcb = 2'b11; e.uop = 2'b11;
    if (!legal(op)) begin
      e.done = 1'b1;
      step(e, idle_rdy, "decode_illegal");
      model_ill = 1'b1;
      return;
    end
    step(e, idle_rdy, "decode");
    if (op == 6'h23 || op == 6'h2B) begin
      e = blank(ST_MEM_ADDR); e.srca = 1'b1; e.srcb = 2'b10; e.uop = 2'b11;
      step(e, idle_rdy, "mem_addr");
      if (op == 6'h23) begin
        e = blank(ST_MEM_RD); e.iord = 1'b1; e.mrd = 1'b1;
        repeat (mwait) step(e, 1'b0, "mem_rd_wait");
        step(e, 1'b1, "mem_rd");
        e = blank(ST_MEM_WB); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
        step(e, idle_rdy, "mem_wb");
      end else begin
        e = blank(ST_MEM_WR); e.iord = 1'b1; e.mwr = 1'b1;
        repeat (mwait) step(e, 1'b0, "mem_wr_wait");
        e.done = 1'b1;
        step(e, 1'b1, "mem_wr");
      end
    end else if (op == 6'h00) begin
`ifdef CONTROL_JR_EN
      if (fn == 6'h08) begin
        e = blank(ST_JR); e.pcw = 1'b1; e.pcsrc = 2'b11; e.done = 1'b1;
        step(e, idle_rdy, "jr");
        return;
      end
`endif
      e = blank(ST_EXEC_R); e.srca = 1'b1; e.uop = 2'b00;
      step(e, idle_rdy, "exec_r");
      e = blank(ST_R_WB); e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
      step(e, idle_rdy, "r_wb");
    end else if (op == 6'h04) begin
      e = blank(ST_BRANCH); e.srca = 1'b1; e.uop = 2'b01; e.pcwc = 1'b1;
      e.pcsrc = 2'b01; e.done = 1'b1;
      step(e, idle_rdy, "branch");
    end else if (op == 6'h02) begin
      e = blank(ST_JUMP); e.pcw = 1'b1; e.pcsrc = 2'b10; e.done = 1'b1;
      step(e, idle_rdy, "jump");
    end else begin
      e = blank(op == 6'h08 ? ST_ADDI_EXEC : ST_ORI_EXEC);
      e.srca = 1'b1; e.srcb = 2'b10; e.uop = (op == 6'h08) ? 2'b11 : 2'b10;
      step(e, idle_rdy, "imm_exec");
      e = blank(ST_IMM_WB); e.rw = 1'b1; e.done = 1'b1;
      step(e, idle_rdy, "imm_wb");
    end
  endtask

  initial begin
    exp_t e;
    int   d0;
    do_reset(2);
    chk("reset_state", int'(state_dbg), int'(ST_FETCH));
    chk("reset_illegal", int'(illegal_op), 0);
    chk("reset_mem_read", int'(mem_read), 1);
    chk("reset_src_b", int'(ula_src_b), 1);
    chk("reset_ula_op", int'(ula_op), 3);

    run(6'h23, 6'h00, 0, 0, 1'b1);
    chk("lat_lw", last_lat, 5);
    chk("done_lw", done_cnt, 1);

    wr_cnt = 0; d0 = done_cnt;
    run(6'h2B, 6'h00, 0, 3, 1'b0);
    chk("sw_wr_cycles", wr_cnt, 4);
    chk("sw_done_once", done_cnt - d0, 1);

    run(6'h00, 6'h20, 0, 0, 1'b0);  chk("lat_rtype", last_lat, 4);
    run(6'h04, 6'h00, 0, 0, 1'b1);  chk("lat_beq", last_lat, 3);
    run(6'h02, 6'h00, 0, 0, 1'b0);  chk("lat_j", last_lat, 3);
    run(6'h08, 6'h00, 0, 0, 1'b1);  chk("lat_addi", last_lat, 4);
    run(6'h0D, 6'h00, 0, 0, 1'b0);  chk("lat_ori", last_lat, 4);
    run(6'h2B, 6'h00, 0, 0, 1'b1);  chk("lat_sw", last_lat, 4);

    run(6'h3F, 6'h00, 0, 0, 1'b1);
    chk("illegal_set", int'(illegal_op), 1);
    run(6'h23, 6'h00, 0, 0, 1'b1);
    chk("illegal_sticky", int'(illegal_op), 1);

    run(6'h00, 6'h08, 0, 0, 1'b0);
`ifdef CONTROL_JR_EN
    chk("lat_jr", last_lat, 3);
`else
    chk("lat_jr", last_lat, 4);
`endif

    run(6'h23, 6'h00, 2, 2, 1'b0);

    do_reset(2);
    chk("illegal_cleared", int'(illegal_op), 0);

    // Reset arriving while lw waits in MEM_RD
    opcode = 6'h23;
    e = fetch_e(); e.pcw = 1'b1; e.irw = 1'b1; step(e, 1'b1, "rst_rd_fetch");
    e = blank(ST_DECODE); e.srcb = 2'b11; e.uop = 2'b11; step(e, 1'b1, "rst_rd_decode");
    e = blank(ST_MEM_ADDR); e.srca = 1'b1; e.srcb = 2'b10; e.uop = 2'b11;
    step(e, 1'b1, "rst_rd_addr");
    reset = 1'b1;
    e = blank(ST_MEM_RD); e.iord = 1'b1; e.mrd = 1'b1; step(e, 1'b1, "rst_rd_cycle");
    reset = 1'b0;
    model_ill = 1'b0;
    chk("rst_rd_state", int'(state_dbg), int'(ST_FETCH));
    chk("rst_rd_reg_write", int'(reg_write), 0);
    run(6'h23, 6'h00, 0, 0, 1'b1);
    chk("lat_lw_after_rst", last_lat, 5);

    // Reset arriving while sw holds mem_write
    opcode = 6'h2B;
    e = fetch_e(); e.pcw = 1'b1; e.irw = 1'b1; step(e, 1'b1, "rst_wr_fetch");
    e = blank(ST_DECODE); e.srcb = 2'b11; e.uop = 2'b11; step(e, 1'b0, "rst_wr_decode");
    e = blank(ST_MEM_ADDR); e.srca = 1'b1; e.srcb = 2'b10; e.uop = 2'b11;
    step(e, 1'b0, "rst_wr_addr");
    reset = 1'b1;
    e = blank(ST_MEM_WR); e.iord = 1'b1; step(e, 1'b1, "rst_wr_cycle");
    reset = 1'b0;
    model_ill = 1'b0;
    chk("rst_wr_state", int'(state_dbg), int'(ST_FETCH));
    run(6'h2B, 6'h00, 0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
